// File: rtl/cursor_blink_ctrl.sv
// Cursor visibility control: synchronises the blink timer, applies phase changes at frame
// boundaries, forces the cursor solid after character writes and on a stalled timer.
module cursor_blink_ctrl #(
   parameter int HOLD_FRAMES  = 2,
   parameter int STALL_CYCLES = 33554432,
   parameter int STALL_W      = 26
) (
   input  logic clk,
   input  logic reset_n,
   input  logic timer_in,
   input  logic enable,
   input  logic frame_start,
   input  logic char_wr,
   input  logic cursor_cell,
   output logic cursor_on,
   output logic cursor_pix_en,
   output logic blink_tick,
   output logic timer_stall
);

   // A zero hold count still needs a one-bit register to keep the datapath legal.
   localparam int                 HOLD_W    = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);
   localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_FRAMES);
   localparam logic [HOLD_W-1:0]  HOLD_ZERO = {HOLD_W{1'b0}};
   localparam logic [HOLD_W-1:0]  HOLD_ONE  = HOLD_W'(1);
   localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);
   localparam logic [STALL_W-1:0] STALL_ONE = STALL_W'(1);

   logic               sync1_r;
   logic               sync2_r;
   logic               prev_r;
   logic [HOLD_W-1:0]  hold_cnt_r;
   logic [STALL_W-1:0] stall_cnt_r;

   logic               edge_s;
   logic               target_s;
   logic               cursor_nxt_s;
   logic [HOLD_W-1:0]  hold_cnt_nxt_s;
   logic [STALL_W-1:0] stall_cnt_nxt_s;

   // Next-state logic for the stall watchdog, hold counter and displayed phase.
   always_comb begin
      edge_s          = sync2_r ^ prev_r;
      stall_cnt_nxt_s = stall_cnt_r;
      hold_cnt_nxt_s  = hold_cnt_r;
      target_s        = sync2_r;
      cursor_nxt_s    = cursor_on;

      if (edge_s) begin
         stall_cnt_nxt_s = {STALL_W{1'b0}};
      end else if (stall_cnt_r == STALL_MAX) begin
         stall_cnt_nxt_s = STALL_MAX;
      end else begin
         stall_cnt_nxt_s = stall_cnt_r + STALL_ONE;
      end

      // A write on a frame boundary reloads rather than decrements.
      if (char_wr) begin
         hold_cnt_nxt_s = HOLD_LOAD;
      end else if (frame_start && (hold_cnt_r != HOLD_ZERO)) begin
         hold_cnt_nxt_s = hold_cnt_r - HOLD_ONE;
      end else begin
         hold_cnt_nxt_s = hold_cnt_r;
      end

      if ((hold_cnt_r != HOLD_ZERO) || timer_stall) begin
         target_s = 1'b1;
      end else begin
         target_s = sync2_r;
      end

      if (char_wr) begin
         cursor_nxt_s = 1'b1;
      end else if (frame_start) begin
         cursor_nxt_s = target_s;
      end else begin
         cursor_nxt_s = cursor_on;
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1_r     <= 1'b0;
         sync2_r     <= 1'b0;
         prev_r      <= 1'b0;
         hold_cnt_r  <= HOLD_ZERO;
         stall_cnt_r <= {STALL_W{1'b0}};
         cursor_on   <= 1'b0;
         blink_tick  <= 1'b0;
         timer_stall <= 1'b0;
      end else begin
         sync1_r     <= timer_in;
         sync2_r     <= sync1_r;
         prev_r      <= sync2_r;
         hold_cnt_r  <= hold_cnt_nxt_s;
         stall_cnt_r <= stall_cnt_nxt_s;
         cursor_on   <= cursor_nxt_s;
         blink_tick  <= (cursor_nxt_s != cursor_on);
         timer_stall <= (stall_cnt_nxt_s == STALL_MAX);
      end
   end

   assign cursor_pix_en = cursor_cell & cursor_on & enable;

endmodule

// File: tb/tb_cursor_blink_ctrl.sv
// Self-checking bench for cursor_blink_ctrl: directed scenarios followed by random traffic,
// all compared against a behavioural model of the cursor rules.
module tb_cursor_blink_ctrl;

   localparam int HOLD  = 2;
   localparam int STALL = 64;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic timer_in = 1'b0;
   logic enable = 1'b0;
   logic frame_start = 1'b0;
   logic char_wr = 1'b0;
   logic cursor_cell = 1'b0;
   logic cursor_on;
   logic cursor_pix_en;
   logic blink_tick;
   logic timer_stall;

   int checks = 0;
   int errors = 0;

   // Model state: timer level delayed by two clocks, quiet time since the delayed level moved,
   // frames of forced visibility left, and the expected registered outputs.
   bit m_d0, m_d1, m_d2;
   int m_quiet;
   int m_frames;
   bit m_cursor, m_tick, m_stall;

   cursor_blink_ctrl #(.HOLD_FRAMES(HOLD), .STALL_CYCLES(STALL), .STALL_W(7)) dut (
      .clk(clk), .reset_n(reset_n), .timer_in(timer_in), .enable(enable),
      .frame_start(frame_start), .char_wr(char_wr), .cursor_cell(cursor_cell),
      .cursor_on(cursor_on), .cursor_pix_en(cursor_pix_en),
      .blink_tick(blink_tick), .timer_stall(timer_stall)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      bit moved, want, new_cursor;
      int new_quiet, new_frames;
      if (!reset_n) begin
         {m_d0, m_d1, m_d2} = 3'b000;
         m_quiet = 0; m_frames = 0;
         m_cursor = 1'b0; m_tick = 1'b0; m_stall = 1'b0;
      end else begin
         moved      = (m_d1 != m_d2);
         new_quiet  = moved ? 0 : ((m_quiet < STALL) ? m_quiet + 1 : STALL);
         want       = ((m_frames > 0) || m_stall) ? 1'b1 : m_d1;
         new_cursor = char_wr ? 1'b1 : (frame_start ? want : m_cursor);
         new_frames = char_wr ? HOLD : ((frame_start && m_frames > 0) ? m_frames - 1 : m_frames);
         m_tick     = (new_cursor != m_cursor);
         m_cursor   = new_cursor;
         m_quiet    = new_quiet;
         m_stall    = (new_quiet == STALL);
         m_frames   = new_frames;
         m_d2 = m_d1; m_d1 = m_d0; m_d0 = timer_in;
      end
   endtask

   task automatic check_all();
      chk("cursor_on", cursor_on, m_cursor);
      chk("blink_tick", blink_tick, m_tick);
      chk("timer_stall", timer_stall, m_stall);
      chk("cursor_pix_en", cursor_pix_en, cursor_cell & m_cursor & enable);
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) step();
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic pulse_char();
      char_wr = 1'b1;
      step();
      char_wr = 1'b0;
   endtask

   initial begin
      // 1: reset, timer rise without a frame, then a frame boundary
      run(2);
      chk("rst_cursor_on", cursor_on, 1'b0);
      chk("rst_blink_tick", blink_tick, 1'b0);
      chk("rst_timer_stall", timer_stall, 1'b0);
      reset_n = 1'b1;
      run(8);
      timer_in = 1'b1;
      run(10);
      chk("no_frame_hold", cursor_on, 1'b0);
      pulse_frame();
      chk("frame_cursor_on", cursor_on, 1'b1);
      chk("frame_tick", blink_tick, 1'b1);
      step();
      chk("tick_one_cycle", blink_tick, 1'b0);

      // 2: edges inside a frame collapse; only the level at frame_start counts
      timer_in = 1'b0; run(3);
      timer_in = 1'b1; run(6);
      pulse_frame();
      chk("collapse_cursor", cursor_on, 1'b1);
      chk("collapse_tick", blink_tick, 1'b0);
      timer_in = 1'b0; run(4);
      pulse_frame();
      chk("fall_cursor", cursor_on, 1'b0);
      chk("fall_tick", blink_tick, 1'b1);

      // 3: char_wr forces the cursor on for two frames
      pulse_char();
      chk("char_immediate", cursor_on, 1'b1);
      run(3); pulse_frame(); chk("hold_f1", cursor_on, 1'b1);
      run(3); pulse_frame(); chk("hold_f2", cursor_on, 1'b1);
      run(3); pulse_frame(); chk("hold_f3_drop", cursor_on, 1'b0);
      pulse_char();
      run(2); pulse_frame();
      run(2);
      frame_start = 1'b1; char_wr = 1'b1; step();
      frame_start = 1'b0; char_wr = 1'b0;
      chk("reload_cursor", cursor_on, 1'b1);
      run(2); pulse_frame(); chk("reload_f1", cursor_on, 1'b1);
      run(2); pulse_frame(); chk("reload_f2", cursor_on, 1'b1);
      run(2); pulse_frame(); chk("reload_f3_drop", cursor_on, 1'b0);

      // 4: stalled timer forces a solid cursor; an edge clears the stall
      run(70);
      chk("stall_set", timer_stall, 1'b1);
      pulse_frame();
      chk("stall_cursor", cursor_on, 1'b1);
      timer_in = 1'b1;
      run(3);
      chk("stall_clear", timer_stall, 1'b0);

      // 5: enable gates only the pixel output
      cursor_cell = 1'b1; enable = 1'b1; #1;
      chk("pix_en_on", cursor_pix_en, 1'b1);
      enable = 1'b0; #1;
      chk("pix_en_off", cursor_pix_en, 1'b0);
      enable = 1'b1; #1;
      chk("pix_en_again", cursor_pix_en, 1'b1);
      cursor_cell = 1'b0; #1;
      chk("pix_cell_off", cursor_pix_en, 1'b0);
      step();

      // 6: reset while holding and stalled discards everything
      timer_in = 1'b0;
      run(70);
      pulse_char();
      reset_n = 1'b0; step(); reset_n = 1'b1;
      chk("mid_rst_cursor", cursor_on, 1'b0);
      chk("mid_rst_stall", timer_stall, 1'b0);
      chk("mid_rst_tick", blink_tick, 1'b0);
      pulse_frame();
      chk("post_rst_frame", cursor_on, 1'b0);

      // Random traffic with alternating busy and silent timer periods
      for (int i = 0; i < 3000; i++) begin
         int mode;
         mode = (i / 400) % 2;
         if (mode == 0 && $urandom_range(0, 7) == 0) timer_in = ~timer_in;
         frame_start = ($urandom_range(0, 15) == 0);
         char_wr     = ($urandom_range(0, 39) == 0);
         enable      = 1'($urandom_range(0, 1));
         cursor_cell = 1'($urandom_range(0, 1));
         reset_n     = ($urandom_range(0, 499) != 0);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
